ndff_sync_filt: RTL

Parametrised multi-bit N-stage synchroniser for asynchronous level signals entering the clk domain, e.g. straps, status lines and interrupt requests. Each bit runs through an independent STAGES-deep flop chain. An optional per-bit stability filter follows the chain, and registered-edge rise/fall pulse outputs are provided. It is the successor to the fixed 1-bit two-flop synchroniser and is used wherever a bundle of independent async levels crosses into a clock domain.

---
 rtl/ndff_sync_filt.sv | 114 +++++++++++
 1 files changed

// File: rtl/ndff_sync_filt.sv
// ndff_sync_filt: multi-bit N-stage level synchroniser into the clk domain.
// Every bit has its own STAGES-deep flop chain. An optional per-bit
// persistence filter follows the chain, and registered-edge rise/fall pulses
// are derived from the final level. Bits are synchronised independently, so
// values that must stay coherent across bits need Gray coding or a handshake
// upstream of this block.

module ndff_sync_filt #(
    parameter int               WIDTH    = 4,
    parameter int               STAGES   = 2,
    parameter int               FILT_CNT = 0,
    parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_chg
);

    // Reject configurations that cannot synchronise at elaboration time.
    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("ndff_sync_filt: STAGES must be >= 2 (got %0d)", STAGES);
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("ndff_sync_filt: WIDTH must be >= 1 (got %0d)", WIDTH);
        end
        if (FILT_CNT < 0) begin : g_bad_filt
            $error("ndff_sync_filt: FILT_CNT must be >= 0 (got %0d)", FILT_CNT);
        end
    endgenerate

    // Synchroniser chain. The attribute keeps these flops packed together and
    // out of retiming so metastability gets the full period to resolve.
    (* async_reg = "true" *) logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] tail;
    logic [WIDTH-1:0] prev_q;

    // Shift data_in through the chain; no logic between stages.
    // NOTE: non-blocking assignments make every stage capture its neighbour's
    // pre-edge value; blocking ones would collapse the chain into one flop.
    // NOTE: the chain is an unpacked array but is still reset element by
    // element, so a reset really discards every in-flight level.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= data_in;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign tail = sync_q[STAGES-1];

    generate
        if (FILT_CNT == 0) begin : g_no_filt
            // Filter bypassed: the chain tail is the output, no extra register.
            assign data_out = tail;
        end else begin : g_filt
            localparam int              CNT_W    = $clog2(FILT_CNT + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

            logic [CNT_W-1:0] cnt_q [WIDTH];
            logic [WIDTH-1:0] filt_q;

            // Per-bit persistence counter: data_out follows tail only after
            // FILT_CNT consecutive edges of disagreement; agreement clears the
            // count, so an interrupted run earns no partial credit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    filt_q <= RST_VAL;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (tail[i] == filt_q[i]) begin
                            cnt_q[i] <= '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            filt_q[i] <= tail[i];
                            cnt_q[i]  <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
            end

            assign data_out = filt_q;
        end
    endgenerate

    // Edge history: prev mirrors data_out one cycle late; it resets to the
    // same value as data_out so no pulse appears during or after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= data_out;
        end
    end

    assign rise    = data_out & ~prev_q;
    assign fall    = ~data_out & prev_q;
    assign any_chg = |(rise | fall);

endmodule
